// File: rtl/aes_round_sequencer.sv
// Control FSM for the iterative AES encrypt datapath: key-expansion gating, round
// index/mux selects, state-register enable and result handshake. Optional macro: AES_SEQ_BACK2BACK_EN.
module aes_round_sequencer #(
  parameter int NR       = 14,
  parameter int KEY_WAIT = 15,
  parameter int RW       = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_valid,
  output logic          start_ready,
  input  logic          key_load,
  output logic          kexp_rst,
  output logic [RW-1:0] round_idx,
  output logic          sel_first,
  output logic          sel_last,
  output logic          state_en,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy
);

  localparam int unsigned CW = (KEY_WAIT > 1) ? $clog2(KEY_WAIT) : 1;

  typedef enum logic [2:0] {IDLE, EXPAND, INIT, ROUND, FINAL, HOLD} state_t;

  state_t        state;
  logic          key_ok;
  logic [CW-1:0] cnt;
  logic          kexp_pulse;
  logic          accept;

  // busy is a registered "not IDLE"; rst overrides the handshake outputs during the reset cycle
`ifdef AES_SEQ_BACK2BACK_EN
  assign start_ready = !rst && (!busy || (state == HOLD && out_ready));
`else
  assign start_ready = !rst && !busy;
`endif
  assign accept   = start_valid && start_ready;
  assign kexp_rst = rst || kexp_pulse;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      key_ok     <= 1'b0;
      cnt        <= '0;
      kexp_pulse <= 1'b0;
      round_idx  <= '0;
      sel_first  <= 1'b0;
      sel_last   <= 1'b0;
      state_en   <= 1'b0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      kexp_pulse <= 1'b0;
      sel_first  <= 1'b0;
      sel_last   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (key_load) key_ok <= 1'b0;
          if (accept) begin
            busy <= 1'b1;
            // a key presented in the accept cycle still forces a fresh expansion
            if (key_ok && !key_load) begin
              state     <= INIT;
              round_idx <= '0;
              sel_first <= 1'b1;
              state_en  <= 1'b1;
            end else begin
              state      <= EXPAND;
              kexp_pulse <= 1'b1;
              cnt        <= '0;
            end
          end
        end
        EXPAND: begin
          if (cnt == CW'(KEY_WAIT - 1)) begin
            key_ok    <= 1'b1;
            cnt       <= '0;
            state     <= INIT;
            round_idx <= '0;
            sel_first <= 1'b1;
            state_en  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        INIT: begin
          state     <= ROUND;
          round_idx <= RW'(1);
        end
        ROUND: begin
          round_idx <= round_idx + 1'b1;
          if (round_idx == RW'(NR - 1)) begin
            state    <= FINAL;
            sel_last <= 1'b1;
          end
        end
        FINAL: begin
          state     <= HOLD;
          state_en  <= 1'b0;
          out_valid <= 1'b1;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (accept) begin
              state     <= INIT;
              round_idx <= '0;
              sel_first <= 1'b1;
              state_en  <= 1'b1;
            end else begin
              state     <= IDLE;
              busy      <= 1'b0;
              round_idx <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench for aes_round_sequencer: timeline reference model, latency table,
// directed corner sequences and randomized traffic.
module tb_aes_round_sequencer;

  localparam int NR = 14;
  localparam int KW = 15;
  localparam int RW = 4;
`ifdef AES_SEQ_BACK2BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_valid = 1'b0;
  logic          start_ready;
  logic          key_load = 1'b0;
  logic          kexp_rst;
  logic [RW-1:0] round_idx;
  logic          sel_first;
  logic          sel_last;
  logic          state_en;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          busy;

  aes_round_sequencer #(.NR(NR), .KEY_WAIT(KW), .RW(RW)) dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .key_load(key_load), .kexp_rst(kexp_rst), .round_idx(round_idx),
    .sel_first(sel_first), .sel_last(sel_last), .state_en(state_en),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  // Reference model: an operation is a timeline of offsets k since accept.
  // Offsets 1..E expand the key, E+1..E+NR+1 load the state, E+NR+2.. hold the result.
  bit m_act = 1'b0;
  bit m_kok = 1'b0;
  int m_k   = 0;
  int m_e   = 0;

  int s_sr, s_kx, s_ridx, s_sf, s_sl, s_en, s_ov, s_busy;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic sv, input logic kl, input logic ordy);
    bit hold;
    int e_ridx;
    @(posedge clk);
    #1;
    rst = r; start_valid = sv; key_load = kl; out_ready = ordy;
    @(negedge clk);
    cyc++;
    s_sr = int'(start_ready); s_kx = int'(kexp_rst); s_ridx = int'(round_idx);
    s_sf = int'(sel_first);   s_sl = int'(sel_last); s_en = int'(state_en);
    s_ov = int'(out_valid);   s_busy = int'(busy);
    hold = m_act && (m_k >= m_e + NR + 2);
    if (!m_act || m_k <= m_e) e_ridx = 0;
    else if (m_k <= m_e + NR + 1) e_ridx = m_k - m_e - 1;
    else e_ridx = NR;
    if (chk_en) begin
      chk("busy", s_busy, int'(m_act));
      chk("round_idx", s_ridx, e_ridx);
      chk("sel_first", s_sf, int'(m_act && m_k == m_e + 1));
      chk("sel_last", s_sl, int'(m_act && m_k == m_e + NR + 1));
      chk("state_en", s_en, int'(m_act && m_k >= m_e + 1 && m_k <= m_e + NR + 1));
      chk("out_valid", s_ov, int'(hold));
      chk("kexp_rst", s_kx, int'(r || (m_act && m_e > 0 && m_k == 1)));
      chk("start_ready", s_sr, int'(!r && (!m_act || (B2B && hold && ordy))));
      chk("first_last_excl", s_sf & s_sl, 0);
    end
    if (r) begin
      m_act = 1'b0;
      m_kok = 1'b0;
    end else if (!m_act) begin
      if (sv) begin
        m_e   = (m_kok && !kl) ? 0 : KW;
        m_act = 1'b1;
        m_k   = 1;
        m_kok = 1'b1;
      end else if (kl) begin
        m_kok = 1'b0;
      end
    end else if (hold && ordy) begin
      if (B2B && sv) begin
        m_k = 1;
        m_e = 0;
      end else begin
        m_act = 1'b0;
      end
    end else begin
      m_k++;
    end
  endtask

  task automatic run_op(input logic kl, input int kl_mid, input int hold,
                        output int first_at, output int last_at, output int valid_at,
                        output int en_cnt, output int kexp_cnt, output int held);
    int  t;
    bit  done;
    logic ordy;
    first_at = -1; last_at = -1; valid_at = -1;
    en_cnt = 0; kexp_cnt = 0; held = 0; done = 1'b0;
    if (kl) step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    t = cyc;
    chk("accept_ready", s_sr, 1);
    for (int i = 0; i < 200 && !done; i++) begin
      ordy = (held >= hold);
      // while the result is being held back, keep requesting a start that must be refused
      step(1'b0, !ordy, (kl_mid >= 0 && i + 1 == kl_mid), ordy);
      if (s_sf != 0 && first_at < 0) first_at = cyc - t;
      if (s_sl != 0 && last_at < 0) last_at = cyc - t;
      if (s_ov != 0 && valid_at < 0) valid_at = cyc - t;
      en_cnt   += s_en;
      kexp_cnt += s_kx;
      if (s_ov != 0 && !ordy) held++;
      if (s_ov != 0 && ordy) done = 1'b1;
    end
    if (!done) chk("op_timeout", 0, 1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("idle_after_handshake", s_busy, 0);
  endtask

  typedef struct {
    logic kl;
    int   kl_mid;
    int   hold;
    int   e_first;
    int   e_last;
    int   e_valid;
    int   e_en;
    int   e_kexp;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int first_at, last_at, valid_at, en_cnt, kexp_cnt, held;
    bit found;
    int vq[$];
    int fq[$];
    int end_cyc;
    bit hit;

    tbl[0] = '{kl: 1'b0, kl_mid: -1, hold: 0, e_first: KW + 1, e_last: KW + NR + 1, e_valid: KW + NR + 2, e_en: NR + 1, e_kexp: 1};
    tbl[1] = '{kl: 1'b0, kl_mid: -1, hold: 0, e_first: 1, e_last: NR + 1, e_valid: NR + 2, e_en: NR + 1, e_kexp: 0};
    tbl[2] = '{kl: 1'b0, kl_mid: -1, hold: 5, e_first: 1, e_last: NR + 1, e_valid: NR + 2, e_en: NR + 1, e_kexp: 0};
    tbl[3] = '{kl: 1'b1, kl_mid: -1, hold: 0, e_first: KW + 1, e_last: KW + NR + 1, e_valid: KW + NR + 2, e_en: NR + 1, e_kexp: 1};
    tbl[4] = '{kl: 1'b0, kl_mid: 5,  hold: 0, e_first: 1, e_last: NR + 1, e_valid: NR + 2, e_en: NR + 1, e_kexp: 0};
    tbl[5] = '{kl: 1'b0, kl_mid: -1, hold: 3, e_first: 1, e_last: NR + 1, e_valid: NR + 2, e_en: NR + 1, e_kexp: 0};

    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_start_ready", s_sr, 0);
    chk("rst_kexp_rst", s_kx, 1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_rst_ready", s_sr, 1);
    chk("post_rst_ridx", s_ridx, 0);

    for (int i = 0; i < 6; i++) begin
      run_op(tbl[i].kl, tbl[i].kl_mid, tbl[i].hold, first_at, last_at, valid_at, en_cnt, kexp_cnt, held);
      chk("tbl_first", first_at, tbl[i].e_first);
      chk("tbl_last", last_at, tbl[i].e_last);
      chk("tbl_valid", valid_at, tbl[i].e_valid);
      chk("tbl_state_en_cycles", en_cnt, tbl[i].e_en);
      chk("tbl_kexp_pulses", kexp_cnt, tbl[i].e_kexp);
      chk("tbl_held", held, tbl[i].hold);
    end

    // reset in the middle of the rounds
    step(1'b0, 1'b1, 1'b0, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      if (s_ridx == 6) found = 1'b1;
    end
    if (!found) chk("ridx6_timeout", 0, 1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("ridx_at_rst", s_ridx, 7);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("abort_busy", s_busy, 0);
    chk("abort_ridx", s_ridx, 0);
    chk("abort_valid", s_ov, 0);
    run_op(1'b0, -1, 0, first_at, last_at, valid_at, en_cnt, kexp_cnt, held);
    chk("abort_reexpand_kexp", kexp_cnt, 1);
    chk("abort_reexpand_first", first_at, KW + 1);

    // start_valid and out_ready held high continuously
    for (int i = 0; i < 90; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1);
      if (s_ov != 0) vq.push_back(cyc);
      if (s_sf != 0) fq.push_back(cyc);
    end
    end_cyc = cyc;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      if (s_busy == 0) found = 1'b1;
    end
    if (!found) chk("drain_timeout", 0, 1);
    chk("b2b_count_ok", int'(vq.size() >= 4), 1);
    for (int i = 1; i < vq.size(); i++) chk("b2b_period", vq[i] - vq[i-1], B2B ? NR + 2 : NR + 3);
    for (int i = 0; i < vq.size(); i++) begin
      if (vq[i] + 2 <= end_cyc) begin
        hit = 1'b0;
        foreach (fq[j]) if (fq[j] == vq[i] + (B2B ? 1 : 2)) hit = 1'b1;
        chk("b2b_first_after_handshake", int'(hit), 1);
      end
    end

    // randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(63) == 0), $urandom_range(1), ($urandom_range(7) == 0), $urandom_range(1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout at cycle %0d: got 1 expected 0", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
- Control FSM for the iterative AES-256 encryption datapath: SubBytes/ShiftRows/MixColumns/AddRoundKey, one round per clock.
- Accepts a start request and gates key-expansion restarts.
- Drives round index, first/last-round mux selects and state-register enable.
- Holds the result-valid handshake until it is consumed.
- Replaces the ad-hoc counters inside the encrypt top level; the datapath becomes purely combinational plus one state register.

Parameters:
NR, 14, number of AES rounds (10/12/14 for Nk=4/6/8)
KEY_WAIT, 15, clock cycles the key-expansion block needs after its reset before all round keys are stable
RW, 4, width of round_idx; must satisfy 2^RW > NR

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, synchronous, active-high
start_valid  in  1  request to encrypt the block currently on the datapath input
start_ready  out  1  sequencer can accept start
key_load  in  1  new cipher key presented (single-cycle pulse)
kexp_rst  out  1  restart pulse to the key-expansion block
round_idx  out  RW  round-key select for the datapath
sel_first  out  1  state register loads plaintext XOR round key 0
sel_last  out  1  datapath bypasses MixColumns (final round)
state_en  out  1  state register load enable
out_valid  out  1  ciphertext stable on the datapath output
out_ready  in  1  consumer accepts ciphertext
busy  out  1  high in any state other than IDLE

Behaviour:
- States: IDLE, EXPAND, INIT, ROUND, FINAL, HOLD.
- Internal flag key_ok: cleared by rst; cleared by key_load while in IDLE; set when EXPAND completes.
- key_load outside IDLE is ignored. The key must not change during an operation.
- start_ready = 1 only in IDLE. Accept = start_valid && start_ready.
- IDLE, on accept:
  - key_ok = 1: go to INIT.
  - key_ok = 0: go to EXPAND.
- EXPAND:
  - kexp_rst = 1 in the first EXPAND cycle only.
  - Internal counter runs from 0 to KEY_WAIT-1.
  - After KEY_WAIT cycles in EXPAND, set key_ok and go to INIT.
- INIT (1 cycle): round_idx = 0, sel_first = 1, state_en = 1, then go to ROUND with round_idx = 1.
- ROUND: state_en = 1, round_idx increments every cycle. When round_idx = NR-1, go to FINAL.
- FINAL (1 cycle): round_idx = NR, sel_last = 1, state_en = 1, then go to HOLD.
- HOLD:
  - out_valid = 1, state_en = 0; round_idx holds NR.
  - On out_ready, go to IDLE; out_valid drops in the next cycle.
- Latency, accept in cycle t:
  - key_ok = 1: out_valid first high at t+NR+2.
  - key_ok = 0: out_valid first high at t+NR+2+KEY_WAIT.
- Reset values: start_ready = 0 during the rst cycle, then 1 in IDLE. kexp_rst = 1 while rst is high. All other outputs 0, round_idx = 0, counters 0, key_ok = 0.
- rst mid-operation: abort immediately; next cycle in IDLE with all outputs at reset values. The next start re-expands the key.
- sel_first and sel_last are never high in the same cycle. state_en is high exactly NR+1 cycles per operation.
- out_valid, once high, stays high with round_idx stable until out_ready.
- start_valid asserted while busy: not accepted, no side effects.

Optional Feature:
- Macro AES_SEQ_BACK2BACK_EN.
- Defined:
  - In HOLD, start_ready = out_ready.
  - A start accepted in the same cycle as the output handshake goes directly to INIT (key_ok is necessarily 1), skipping IDLE.
  - Back-to-back throughput is one block per NR+2 cycles.
- Undefined: start_ready only in IDLE. Back-to-back throughput is one block per NR+3 cycles.

Test Plan:
1. rst then start_valid=1 with key_ok=0, NR=14, KEY_WAIT=15, out_ready=1:
   - kexp_rst pulses one cycle after accept.
   - sel_first at t+16.
   - sel_last with round_idx=14 at t+30.
   - out_valid at t+31.
2. Second start with no key_load:
   - No kexp_rst.
   - round_idx sequence 0,1,...,14 on consecutive cycles.
   - out_valid at t+16.
   - state_en high for exactly 15 cycles.
3. out_ready held 0 for 5 cycles in HOLD:
   - out_valid stays 1 and round_idx stays 14.
   - start_valid during that time is not accepted.
   - Return to IDLE one cycle after out_ready=1.
4. key_load in IDLE, then start: EXPAND is re-entered. key_load pulsed during ROUND: ignored, next start skips EXPAND.
5. rst asserted at round_idx=7: next cycle busy=0, round_idx=0, out_valid=0. Following start runs full EXPAND.
6. With AES_SEQ_BACK2BACK_EN, start_valid and out_ready both held 1:
   - sel_first in the cycle after each handshake.
   - out_valid every 16 cycles.
   - Without the macro, out_valid every 17 cycles.
